// File: rtl/cp0_pkg.sv
// cp0_pkg: register indices, field positions and exception codes for cp0_ext.
package cp0_pkg;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam int SR_IM_MSB = 15;
  localparam int SR_IM_LSB = 8;
  localparam int SR_EXL = 1;
  localparam int SR_IE = 0;
  localparam int CAUSE_BD = 31;
  localparam int CAUSE_TI = 30;
  localparam int CAUSE_IP_MSB = 15;
  localparam int CAUSE_IP_LSB = 8;
  localparam int CAUSE_SW_MSB = 9;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_EXC_LSB = 2;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
  function automatic logic is_addr_exc(input logic [4:0] c);
    return c == EXC_ADEL || c == EXC_ADES;
  endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-interrupt flag TI.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter bit TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wr,
  input  logic        compare_wr_commit,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);
  if (TIMER_EN) begin : g_on
    logic [31:0] cnt, cmp, inc;
    logic t;
    assign inc = cnt + 32'd1;
    // only an increment can raise TI; a Compare write always wins over a set
    always_ff @(posedge clk)
      if (reset) begin
        cnt <= '0;
        cmp <= '0;
        t   <= 1'b0;
      end else begin
        cnt <= count_wr ? write_data : inc;
        if (compare_wr_commit) cmp <= write_data;
        t <= compare_wr_commit ? 1'b0 : (t | (~count_wr & (inc == cmp)));
      end
    assign count = cnt;
    assign compare = cmp;
    assign ti = t;
  end else begin : g_off
    assign count = '0;
    assign compare = '0;
    assign ti = 1'b0;
  end
endmodule

// File: rtl/cp0_ext.sv
// cp0_ext: MIPS CP0 with configurable hardware interrupts, software interrupts and a Count/Compare timer.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          HW_INT_W   = 5,
  parameter bit          TIMER_EN   = 1'b1,
  parameter logic [31:0] PRID_VALUE = 32'h0000_0700
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          number,
  input  logic                write_enable,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  input  logic [31:0]         vpc,
  input  logic                bd_in,
  input  logic [4:0]          exc_code_in,
  input  logic [31:0]         bad_vaddr_in,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                exl_clr,
  output logic [31:0]         epc_out,
  output logic                request
);
  logic [7:0] im, ip, pend;
  logic exl, ie, bd, ti, int_req, exc_req, take, wr_commit;
  logic [1:0] sw;
  logic [4:0] hw_q, hw_ext, exc_code;
  logic [31:0] epc, bad_vaddr, count, compare;
  always_comb begin
    hw_ext = '0;
    hw_ext[HW_INT_W-1:0] = hw_int;
  end
  // pending uses the live lines so request does not lag hw_int
  assign ip = {ti, hw_q, sw};
  assign pend = im & {ti, hw_ext, sw};
  assign int_req = ie & ~exl & |pend;
  assign exc_req = ~exl & (exc_code_in != EXC_INT);
  assign take = int_req | exc_req;
  assign request = take;
  assign wr_commit = write_enable & ~exl_clr & ~take;
  assign epc_out = (write_enable && number == REG_EPC) ? write_data : epc;
  cp0_timer #(.TIMER_EN(TIMER_EN)) u_timer (
    .clk(clk),
    .reset(reset),
    .count_wr(wr_commit && number == REG_COUNT),
    .compare_wr_commit(wr_commit && number == REG_COMPARE),
    .write_data(write_data),
    .count(count),
    .compare(compare),
    .ti(ti)
  );
  always_ff @(posedge clk) hw_q <= reset ? 5'd0 : hw_ext;
  always_ff @(posedge clk)
    if (reset) begin
      im <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      sw <= '0;
      exc_code <= '0;
      epc <= '0;
      bad_vaddr <= '0;
    end else if (exl_clr) begin
      exl <= 1'b0;
    end else if (take) begin
      exl <= 1'b1;
      exc_code <= int_req ? EXC_INT : exc_code_in;
      bd <= bd_in;
      epc <= bd_in ? vpc - 32'd4 : vpc;
      if (!int_req && is_addr_exc(exc_code_in)) bad_vaddr <= bad_vaddr_in;
    end else if (wr_commit) begin
      case (number)
        REG_SR: begin
          im <= write_data[SR_IM_MSB:SR_IM_LSB];
          exl <= write_data[SR_EXL];
          ie <= write_data[SR_IE];
        end
        REG_CAUSE: sw <= write_data[CAUSE_SW_MSB:CAUSE_IP_LSB];
        REG_EPC: epc <= write_data;
        default: ;
      endcase
    end
  always_comb begin
    read_data = '0;
    case (number)
      REG_BADVADDR: read_data = bad_vaddr;
      REG_COUNT: read_data = count;
      REG_COMPARE: read_data = compare;
      REG_SR: begin
        read_data[SR_IM_MSB:SR_IM_LSB] = im;
        read_data[SR_EXL] = exl;
        read_data[SR_IE] = ie;
      end
      REG_CAUSE: begin
        read_data[CAUSE_BD] = bd;
        read_data[CAUSE_TI] = ti;
        read_data[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip;
        read_data[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc_code;
      end
      REG_EPC: read_data = epc;
      REG_PRID: read_data = PRID_VALUE;
      default: ;
    endcase
  end
endmodule
